// File: rtl/opsg_pkg.sv
// Shared definitions for the PSG register interface: channel and type codes,
// field widths, the latch register layout and the tone nibble/upper-field merge.
package opsg_pkg;

  localparam int unsigned TONE_W  = 10;
  localparam int unsigned VOL_W   = 4;
  localparam int unsigned NOISE_W = 3;

  localparam logic [1:0] CH_TONE0 = 2'd0;
  localparam logic [1:0] CH_TONE1 = 2'd1;
  localparam logic [1:0] CH_TONE2 = 2'd2;
  localparam logic [1:0] CH_NOISE = 2'd3;

  localparam logic TYPE_TONE = 1'b0;
  localparam logic TYPE_VOL  = 1'b1;

  localparam logic [VOL_W-1:0] VOL_SILENT = 4'hF;

  // Register selected by the most recent latch byte
  typedef struct packed {
    logic [1:0] ch;
    logic       typ;
  } latch_t;

  // Latch bytes replace the low nibble, data bytes replace the upper six bits
  function automatic logic [TONE_W-1:0] tone_update(input logic [TONE_W-1:0] old,
                                                    input logic [7:0]        data,
                                                    input logic              is_latch);
    if (is_latch) tone_update = {old[TONE_W-1:4], data[3:0]};
    else          tone_update = {data[5:0], old[3:0]};
  endfunction

endpackage

// File: rtl/opsg_busy_timer.sv
// READY emulation: after a start pulse, ready drops for exactly BUSY_CYCLES
// clocks beginning the cycle after the start edge. BUSY_CYCLES=0 keeps ready high.
// Ports: clk, reset_n (async active-low), start (accepted write), ready (registered).
module opsg_busy_timer #(
  parameter int unsigned BUSY_CYCLES = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  output logic ready
);

  localparam int unsigned CNT_W = (BUSY_CYCLES == 0) ? 1 : $clog2(BUSY_CYCLES + 1);
  localparam int unsigned LOAD  = (BUSY_CYCLES == 0) ? 0 : BUSY_CYCLES - 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Counter is loaded with BUSY_CYCLES-1 so the terminal-count cycle is the last busy one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start && (BUSY_CYCLES != 0)) begin
            state <= BUSY;
            cnt   <= CNT_W'(LOAD);
            ready <= 1'b0;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state <= IDLE;
            ready <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/opsg_reg_if.sv
// SN76489-style CPU write decoder and register file feeding the tone, noise
// and volume channels.
// Ports: clk, reset_n (async active-low), wr_en/wr_data (byte strobe),
// ready, write_drop (pulse), tone0..2, noise_ctrl, noise_rst (pulse), vol0..3.
module opsg_reg_if
  import opsg_pkg::*;
#(
  parameter int unsigned      BUSY_CYCLES = 32,
  parameter logic [VOL_W-1:0] VOL_RESET   = VOL_SILENT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               wr_en,
  input  logic [7:0]         wr_data,
  output logic               ready,
  output logic               write_drop,
  output logic [TONE_W-1:0]  tone0,
  output logic [TONE_W-1:0]  tone1,
  output logic [TONE_W-1:0]  tone2,
  output logic [NOISE_W-1:0] noise_ctrl,
  output logic               noise_rst,
  output logic [VOL_W-1:0]   vol0,
  output logic [VOL_W-1:0]   vol1,
  output logic [VOL_W-1:0]   vol2,
  output logic [VOL_W-1:0]   vol3
);

  latch_t latch_q;
  latch_t tgt;
  logic   accept;
  logic   is_latch;

  opsg_busy_timer #(.BUSY_CYCLES(BUSY_CYCLES)) u_busy_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (accept),
    .ready   (ready)
  );

  // Target register: a latch byte names it directly, a data byte reuses the last latch
  always_comb begin
    accept   = wr_en & ready;
    is_latch = wr_data[7];
    tgt      = latch_q;
    if (is_latch) begin
      tgt.ch  = wr_data[6:5];
      tgt.typ = wr_data[4];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      latch_q    <= '{ch: CH_TONE0, typ: TYPE_TONE};
      tone0      <= '0;
      tone1      <= '0;
      tone2      <= '0;
      noise_ctrl <= '0;
      vol0       <= VOL_RESET;
      vol1       <= VOL_RESET;
      vol2       <= VOL_RESET;
      vol3       <= VOL_RESET;
      noise_rst  <= 1'b0;
      write_drop <= 1'b0;
    end else begin
      noise_rst  <= 1'b0;
      write_drop <= wr_en & ~ready;
      if (accept) begin
        latch_q <= tgt;
        if (tgt.typ == TYPE_VOL) begin
          case (tgt.ch)
            CH_TONE0: vol0 <= wr_data[3:0];
            CH_TONE1: vol1 <= wr_data[3:0];
            CH_TONE2: vol2 <= wr_data[3:0];
            default:  vol3 <= wr_data[3:0];
          endcase
        end else if (tgt.ch == CH_NOISE) begin
          // Any noise write restarts the LFSR, regardless of value
          noise_ctrl <= wr_data[2:0];
          noise_rst  <= 1'b1;
        end else begin
          case (tgt.ch)
            CH_TONE0: tone0 <= tone_update(tone0, wr_data, is_latch);
            CH_TONE1: tone1 <= tone_update(tone1, wr_data, is_latch);
            default:  tone2 <= tone_update(tone2, wr_data, is_latch);
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_opsg_reg_if.sv
// Directed bench for opsg_reg_if with three instances (BUSY_CYCLES = 2, 32, 0)
// sharing clock, reset and write data; each has its own write strobe.
module tb_opsg_reg_if;

  logic       clk;
  logic       reset_n;
  logic [7:0] wr_data;
  logic       wr_en2, wr_en32, wr_en0;

  int vectors;
  int miscompares;

  logic       ready2, drop2, nrst2;
  logic [9:0] t0_2, t1_2, t2_2;
  logic [2:0] nc2;
  logic [3:0] v0_2, v1_2, v2_2, v3_2;

  logic       ready32, drop32, nrst32;
  logic [9:0] t0_32, t1_32, t2_32;
  logic [2:0] nc32;
  logic [3:0] v0_32, v1_32, v2_32, v3_32;

  logic       ready0, drop0, nrst0;
  logic [9:0] t0_0, t1_0, t2_0;
  logic [2:0] nc0;
  logic [3:0] v0_0, v1_0, v2_0, v3_0;

  opsg_reg_if #(.BUSY_CYCLES(2), .VOL_RESET(4'hF)) u_b2 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en2), .wr_data(wr_data),
    .ready(ready2), .write_drop(drop2), .tone0(t0_2), .tone1(t1_2), .tone2(t2_2),
    .noise_ctrl(nc2), .noise_rst(nrst2), .vol0(v0_2), .vol1(v1_2), .vol2(v2_2), .vol3(v3_2));

  opsg_reg_if #(.BUSY_CYCLES(32), .VOL_RESET(4'hF)) u_b32 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en32), .wr_data(wr_data),
    .ready(ready32), .write_drop(drop32), .tone0(t0_32), .tone1(t1_32), .tone2(t2_32),
    .noise_ctrl(nc32), .noise_rst(nrst32), .vol0(v0_32), .vol1(v1_32), .vol2(v2_32), .vol3(v3_32));

  opsg_reg_if #(.BUSY_CYCLES(0), .VOL_RESET(4'hF)) u_b0 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en0), .wr_data(wr_data),
    .ready(ready0), .write_drop(drop0), .tone0(t0_0), .tone1(t1_0), .tone2(t2_0),
    .noise_ctrl(nc0), .noise_rst(nrst0), .vol0(v0_0), .vol1(v1_0), .vol2(v2_0), .vol3(v3_0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write2(input logic [7:0] d);
    wr_data = d; wr_en2 = 1'b1;
    tick();
    wr_en2 = 1'b0;
  endtask

  task automatic write32(input logic [7:0] d);
    wr_data = d; wr_en32 = 1'b1;
    tick();
    wr_en32 = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    vectors++; if (t0_2 !== 10'h000 || t1_2 !== 10'h000 || t2_2 !== 10'h000) begin
      miscompares++; $display("FAIL reset_tone: got %h %h %h, expected 000 000 000", t0_2, t1_2, t2_2); end
    vectors++; if ({v0_2, v1_2, v2_2, v3_2} !== 16'hFFFF) begin
      miscompares++; $display("FAIL reset_vol: got %h, expected ffff", {v0_2, v1_2, v2_2, v3_2}); end
    vectors++; if (nc2 !== 3'b000 || nrst2 !== 1'b0) begin
      miscompares++; $display("FAIL reset_noise: got ctrl=%b rst=%b, expected 000 0", nc2, nrst2); end
    vectors++; if ({ready2, ready32, ready0} !== 3'b111) begin
      miscompares++; $display("FAIL reset_ready: got %b, expected 111", {ready2, ready32, ready0}); end
    vectors++; if ({drop2, drop32, drop0} !== 3'b000) begin
      miscompares++; $display("FAIL reset_drop: got %b, expected 000", {drop2, drop32, drop0}); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_tone();
    write2(8'h8E);
    vectors++; if (t0_2 !== 10'h00E) begin
      miscompares++; $display("FAIL tone_latch: got %h, expected 00e", t0_2); end
    vectors++; if (ready2 !== 1'b0) begin
      miscompares++; $display("FAIL busy2_c0: got %b, expected 0", ready2); end
    tick();
    vectors++; if (ready2 !== 1'b0) begin
      miscompares++; $display("FAIL busy2_c1: got %b, expected 0", ready2); end
    tick();
    vectors++; if (ready2 !== 1'b1) begin
      miscompares++; $display("FAIL busy2_end: got %b, expected 1", ready2); end
    tick();
    write2(8'h3F);
    vectors++; if (t0_2 !== 10'h3FE) begin
      miscompares++; $display("FAIL tone_data: got %h, expected 3fe", t0_2); end
    vectors++; if (t1_2 !== 10'h000 || t2_2 !== 10'h000 || nc2 !== 3'b000 || {v0_2, v1_2, v2_2, v3_2} !== 16'hFFFF) begin
      miscompares++; $display("FAIL tone_others: got %h %h %b %h, expected 000 000 000 ffff",
                              t1_2, t2_2, nc2, {v0_2, v1_2, v2_2, v3_2}); end
    tick(); tick(); tick();
  endtask

  task automatic test_vol();
    write2(8'hD5);
    vectors++; if (v2_2 !== 4'h5) begin
      miscompares++; $display("FAIL vol_latch: got %h, expected 5", v2_2); end
    tick(); tick(); tick();
    write2(8'h0A);
    vectors++; if (v2_2 !== 4'hA) begin
      miscompares++; $display("FAIL vol_data: got %h, expected a", v2_2); end
    vectors++; if (t2_2 !== 10'h000 || t0_2 !== 10'h3FE) begin
      miscompares++; $display("FAIL vol_tone_kept: got t2=%h t0=%h, expected 000 3fe", t2_2, t0_2); end
    tick(); tick(); tick();
  endtask

  task automatic test_noise();
    write2(8'hE4);
    vectors++; if (nc2 !== 3'b100 || nrst2 !== 1'b1) begin
      miscompares++; $display("FAIL noise_latch: got ctrl=%b rst=%b, expected 100 1", nc2, nrst2); end
    tick();
    vectors++; if (nrst2 !== 1'b0) begin
      miscompares++; $display("FAIL noise_rst_width1: got %b, expected 0", nrst2); end
    tick(); tick();
    write2(8'h03);
    vectors++; if (nc2 !== 3'b011 || nrst2 !== 1'b1) begin
      miscompares++; $display("FAIL noise_data: got ctrl=%b rst=%b, expected 011 1", nc2, nrst2); end
    tick();
    vectors++; if (nrst2 !== 1'b0) begin
      miscompares++; $display("FAIL noise_rst_width2: got %b, expected 0", nrst2); end
    vectors++; if (v3_2 !== 4'hF || t2_2 !== 10'h000) begin
      miscompares++; $display("FAIL noise_others: got v3=%h t2=%h, expected f 000", v3_2, t2_2); end
    tick(); tick();
  endtask

  task automatic test_drop();
    int low;
    int pulses;
    write32(8'h9F);
    low = 0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (drop32 === 1'b1) pulses++;
      if (i == 5) begin
        vectors++; if (drop32 !== 1'b1 || v0_32 !== 4'hF) begin
          miscompares++; $display("FAIL drop_pulse: got drop=%b vol0=%h, expected 1 f", drop32, v0_32); end
      end
      if (i == 6) begin
        vectors++; if (drop32 !== 1'b0) begin
          miscompares++; $display("FAIL drop_width: got %b, expected 0", drop32); end
      end
      if (ready32 === 1'b1) break;
      low++;
      if (i == 4) begin wr_data = 8'h90; wr_en32 = 1'b1; end
      else wr_en32 = 1'b0;
      tick();
    end
    wr_en32 = 1'b0;
    vectors++; if (low !== 32) begin
      miscompares++; $display("FAIL busy32_len: got %0d, expected 32", low); end
    vectors++; if (pulses !== 1) begin
      miscompares++; $display("FAIL drop_count: got %0d, expected 1", pulses); end
    vectors++; if (v0_32 !== 4'hF) begin
      miscompares++; $display("FAIL drop_vol_kept: got %h, expected f", v0_32); end
    write32(8'h90);
    vectors++; if (v0_32 !== 4'h0) begin
      miscompares++; $display("FAIL drop_retry: got %h, expected 0", v0_32); end
    for (int i = 0; i < 40 && ready32 !== 1'b1; i++) tick();
    vectors++; if (ready32 !== 1'b1) begin
      miscompares++; $display("FAIL retry_ready_timeout: got %b, expected 1", ready32); end
    tick();
  endtask

  task automatic test_reset_mid_busy();
    write32(8'h81);
    vectors++; if (t0_32 !== 10'h001 || ready32 !== 1'b0) begin
      miscompares++; $display("FAIL pre_reset: got t0=%h ready=%b, expected 001 0", t0_32, ready32); end
    repeat (9) tick();
    reset_n = 1'b0;
    #1;
    vectors++; if (ready32 !== 1'b1) begin
      miscompares++; $display("FAIL mid_reset_ready: got %b, expected 1", ready32); end
    vectors++; if (t0_32 !== 10'h000 || {v0_32, v1_32, v2_32, v3_32} !== 16'hFFFF) begin
      miscompares++; $display("FAIL mid_reset_regs: got t0=%h vol=%h, expected 000 ffff",
                              t0_32, {v0_32, v1_32, v2_32, v3_32}); end
    tick();
    reset_n = 1'b1;
    tick();
    write32(8'h01);
    vectors++; if (t0_32 !== 10'h010) begin
      miscompares++; $display("FAIL post_reset_data: got %h, expected 010", t0_32); end
    for (int i = 0; i < 40 && ready32 !== 1'b1; i++) tick();
  endtask

  task automatic test_back_to_back();
    int drops;
    int notready;
    logic [7:0] bytes [3];
    logic [9:0] exp   [3];
    bytes[0] = 8'hA3; bytes[1] = 8'h12; bytes[2] = 8'h05;
    exp[0]   = 10'h003; exp[1] = 10'h123; exp[2] = 10'h053;
    drops = 0;
    notready = 0;
    wr_en0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = bytes[i];
      tick();
      if (drop0 !== 1'b0) drops++;
      if (ready0 !== 1'b1) notready++;
      vectors++; if (t1_0 !== exp[i]) begin
        miscompares++; $display("FAIL b2b_tone1_%0d: got %h, expected %h", i, t1_0, exp[i]); end
    end
    wr_en0 = 1'b0;
    tick();
    if (drop0 !== 1'b0) drops++;
    vectors++; if (drops !== 0 || notready !== 0) begin
      miscompares++; $display("FAIL b2b_ready: got drops=%0d notready=%0d, expected 0 0", drops, notready); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    wr_data     = 8'h00;
    wr_en2      = 1'b0;
    wr_en32     = 1'b0;
    wr_en0      = 1'b0;
    test_reset();
    test_tone();
    test_vol();
    test_noise();
    test_drop();
    test_reset_mid_busy();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
